// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared thread-state encoding and width helper for the barrel core
package barrel_pkg;

  typedef logic [1:0] tstate_t;

  localparam tstate_t ST_IDLE  = 2'b00;
  localparam tstate_t ST_READY = 2'b01;
  localparam tstate_t ST_WAIT  = 2'b10;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int tid_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin pick of the first set bit above ptr, wrapping
module rr_picker #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] tid
);

  logic [N-1:0] rot;
  logic [W-1:0] idx;
  logic [W-1:0] off;

  // rot[i] is the candidate i+1 slots after ptr; N is a power of two so W-bit adds wrap.
  always_comb begin
    rot = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx    = ptr + W'(1) + W'(i);
      rot[i] = elig[idx];
    end
  end

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    found = |elig;
    tid   = found ? (ptr + W'(1) + off) : '0;
  end

endmodule

// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - per-cycle issue arbiter choosing the next hardware thread to fetch
module thread_scheduler
  import barrel_pkg::*;
#(
  parameter int                     NUM_THREADS  = 8,
  parameter int                     PIPE_DEPTH   = 5,
  parameter logic [NUM_THREADS-1:0] BOOT_MASK    = NUM_THREADS'(8'h01),
  localparam int                    BITS_THREADS = tid_bits(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    start_valid,
  input  logic [BITS_THREADS-1:0] start_tid,
  input  logic                    halt_valid,
  input  logic [BITS_THREADS-1:0] halt_tid,
  input  logic                    wait_valid,
  input  logic [BITS_THREADS-1:0] wait_tid,
  input  logic                    done_valid,
  input  logic [BITS_THREADS-1:0] done_tid,
  output logic                    issue_valid,
  output logic [BITS_THREADS-1:0] issue_tid,
  output logic [NUM_THREADS-1:0]  active_mask,
  output logic                    all_idle
);

  localparam int                CD_BITS = tid_bits(PIPE_DEPTH);
  localparam logic [CD_BITS-1:0] CD_LOAD = CD_BITS'(PIPE_DEPTH - 1);

  tstate_t                 state     [NUM_THREADS];
  tstate_t                 state_nxt [NUM_THREADS];
  logic [CD_BITS-1:0]      cd        [NUM_THREADS];
  logic [BITS_THREADS-1:0] ptr;
  logic [NUM_THREADS-1:0]  elig;
  logic [NUM_THREADS-1:0]  nonidle_nxt;
  logic [NUM_THREADS-1:0]  halt_hit, wait_hit, done_hit, start_hit;
  logic                    found;
  logic [BITS_THREADS-1:0] pick;

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      halt_hit[t]  = halt_valid  && (halt_tid  == BITS_THREADS'(t));
      wait_hit[t]  = wait_valid  && (wait_tid  == BITS_THREADS'(t));
      done_hit[t]  = done_valid  && (done_tid  == BITS_THREADS'(t));
      start_hit[t] = start_valid && (start_tid == BITS_THREADS'(t));
    end
  end

  // A wait in the same cycle as a done keeps the thread parked.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      state_nxt[t] = state[t];
      if (halt_hit[t])
        state_nxt[t] = ST_IDLE;
      else if (wait_hit[t] && state[t] == ST_READY)
        state_nxt[t] = ST_WAIT;
      else if (done_hit[t] && !wait_hit[t] && state[t] == ST_WAIT)
        state_nxt[t] = ST_READY;
      else if (start_hit[t] && state[t] == ST_IDLE)
        state_nxt[t] = ST_READY;
      nonidle_nxt[t] = (state_nxt[t] != ST_IDLE);
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      elig[t] = (state[t] == ST_READY) && (cd[t] == '0);
    end
  end

  rr_picker #(
    .N (NUM_THREADS),
    .W (BITS_THREADS)
  ) u_rr_picker (
    .elig  (elig),
    .ptr   (ptr),
    .found (found),
    .tid   (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state[t] <= BOOT_MASK[t] ? ST_READY : ST_IDLE;
        cd[t]    <= '0;
      end
      ptr         <= BITS_THREADS'(NUM_THREADS - 1);
      issue_valid <= 1'b0;
      issue_tid   <= '0;
      active_mask <= BOOT_MASK;
      all_idle    <= (BOOT_MASK == '0);
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state[t] <= state_nxt[t];
      end
      active_mask <= nonidle_nxt;
      all_idle    <= ~|nonidle_nxt;
      // Stall freezes the issue path and every cooldown; thread state still moves.
      if (!stall) begin
        issue_valid <= found;
        issue_tid   <= pick;
        if (found) ptr <= pick;
        for (int t = 0; t < NUM_THREADS; t++) begin
          if (found && pick == BITS_THREADS'(t))
            cd[t] <= CD_LOAD;
          else if (cd[t] != '0)
            cd[t] <= cd[t] - CD_BITS'(1);
        end
      end
    end
  end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Per-cycle issue arbiter for the barrel RISC-V core. Decides which hardware thread fetches next.
- Tracks a state per thread (IDLE/READY/WAIT) and enforces a per-thread re-issue gap, so one thread never has two instructions in the pipeline.
- Picks round-robin among eligible threads. Drives issue_tid into the fetch stage; the tid is then carried down the pipeline registers to writeback.

Parameters:
- NUM_THREADS, 8, number of hardware threads (power of two, >=2).
- PIPE_DEPTH, 5, minimum cycles between two issues of the same tid.
- BOOT_MASK, 8'h01, threads placed in READY by reset (width NUM_THREADS).
- BITS_THREADS, $clog2(NUM_THREADS), localparam, tid width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  global front-end stall; freezes scheduler
- start_valid  in  1  request to start thread start_tid
- start_tid  in  BITS_THREADS  thread to start
- halt_valid  in  1  thread halt_tid retires ecall/halt
- halt_tid  in  BITS_THREADS  thread to halt
- wait_valid  in  1  memory stage reports a long-latency access for wait_tid
- wait_tid  in  BITS_THREADS  thread to park
- done_valid  in  1  memory access for done_tid completed
- done_tid  in  BITS_THREADS  thread to unpark
- issue_valid  out  1  issue_tid is a real issue this cycle (0 = bubble)
- issue_tid  out  BITS_THREADS  thread selected for fetch
- active_mask  out  NUM_THREADS  bit t = thread t not IDLE
- all_idle  out  1  every thread IDLE

Behaviour:
- Reset (synchronous, active-high, rst sampled at posedge clk):
  - Thread t goes to READY if BOOT_MASK[t], else IDLE.
  - All cooldown counters cd[t] = 0; rr pointer = NUM_THREADS-1, so tid 0 wins first.
  - issue_valid = 0, issue_tid = 0.
  - active_mask = BOOT_MASK; all_idle = (BOOT_MASK == 0).
  - rst overrides every other input, including mid-operation.
- Eligibility (combinational): elig[t] = (state[t]==READY) && (cd[t]==0).
- Selection: the first eligible tid scanning upward from ptr+1, modulo NUM_THREADS, wrapping.
- Issue timing: on a posedge with stall=0, issue_valid <= |elig and issue_tid <= the selected tid (0 if none). Latency is 1 cycle from state to output.
- On an issue at that same edge:
  - ptr <= selected tid.
  - cd[selected] <= PIPE_DEPTH-1.
  - Every other nonzero cd decrements by 1.
- Consequence: the same tid reissues no sooner than PIPE_DEPTH edges after its previous issue. With >=PIPE_DEPTH READY threads, no bubbles occur.
- No eligible thread: issue_valid <= 0, ptr unchanged, nonzero cd still decrement.
- stall=1: issue_valid, issue_tid, ptr and all cd hold. State-change inputs are still applied.
- Per-thread state transitions, in per-tid priority order:
  - halt: any state -> IDLE.
  - wait: READY -> WAIT.
  - done: WAIT -> READY.
  - start: IDLE -> READY.
- Ignored events:
  - start on a non-IDLE thread.
  - done on a non-WAIT thread.
  - wait on an IDLE thread.
- Simultaneous events, same tid:
  - halt beats everything.
  - wait + done together: the thread ends in WAIT.
- Different tids: all events apply independently in the same cycle.
- A halted thread keeps its cd decrementing. A thread restarted while cd>0 is READY but not eligible until cd==0.
- A thread's state change at edge k affects eligibility for the issue at edge k+1. The issue at edge k uses pre-edge state.
- active_mask and all_idle are registered and reflect the post-edge state.

Decomposition:
- Shared package barrel_pkg holds:
  - Thread-state encoding: IDLE=2'b00, READY=2'b01, WAIT=2'b10.
  - The BITS_THREADS derivation, reused by the pipeline registers.
- One combinational sub-module, rr_picker (inputs: elig mask, ptr; outputs: found, tid), implemented as a rotate + priority-encode.
- Cooldown counters and the state FSM stay in thread_scheduler.

Test Plan:
- Reset with BOOT_MASK=8'h01, only thread 0 live: issue_valid = 1,0,0,0,0,1,0,… (period 5), issue_tid = 0.
- start tid 1..4 at cycle 1: after warm-up, issue_tid = 0,1,2,3,4,0,… with no bubbles; active_mask = 8'h1F.
- All 8 threads READY, wait on tid 3 at cycle 10: tid 3 skipped (…,2,4,…) until done_tid=3. It then reappears on its next round-robin turn after its cd reaches 0.
- Same-cycle halt_tid=2 and start_tid=2: thread 2 ends IDLE. Same-cycle wait_tid=5 and done_tid=5 on READY thread 5: thread 5 ends WAIT.
- stall held 3 cycles mid-stream: issue_valid/issue_tid frozen; the sequence resumes exactly where it stopped with no tid skipped or repeated.
- rst asserted mid-run with threads in WAIT: next cycle issue_valid=0, active_mask=BOOT_MASK; the following cycle issue_tid=0. Halt all threads: all_idle=1 and issue_valid=0.
